// File: rtl/lix_skid_rd_pkg.sv
// Shared constants for the lix skid-buffer read stage: depth and occupancy codes.
package lix_skid_rd_pkg;

    localparam int LIX_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        LIX_OCC_EMPTY = 2'd0,
        LIX_OCC_ONE   = 2'd1,
        LIX_OCC_FULL  = 2'd2
    } lix_occ_e;

endpackage

// File: rtl/lix_reg.sv
// Valid/enable capture register: loads i_x when both i_vld and i_en are high.
module lix_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_vld,
    input  logic         i_en,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_z
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            o_z <= '0;
        else if (i_vld && i_en)
            o_z <= i_x;
    end

endmodule

// File: rtl/lix_skid_rd.sv
// Two-entry skid buffer with registered upstream ready (o_en).
// Optional LIX_SKID_BYPASS_EN: zero-latency pass-through when the buffer is empty.
module lix_skid_rd
    import lix_skid_rd_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_vld,
    output logic         o_en,
    input  logic [W-1:0] i_x,
    output logic         o_vld,
    input  logic         i_en,
    output logic [W-1:0] o_z,
    output logic [1:0]   o_cnt
);

    lix_occ_e occ_q, occ_d;
    logic     wr_ptr, rd_ptr;
    logic     en_q;
    logic     push, pop, push_st, pop_st, thru, stored_vld;
    logic [W-1:0] last_z;
    logic [LIX_SKID_DEPTH-1:0][W-1:0] entry;

    assign push       = i_vld & en_q;
    assign stored_vld = (occ_q != LIX_OCC_EMPTY);

`ifdef LIX_SKID_BYPASS_EN
    // An empty buffer forwards the incoming word; it is stored only if not popped now.
    assign thru  = push & (occ_q == LIX_OCC_EMPTY) & i_en;
    assign o_vld = stored_vld | (push & (occ_q == LIX_OCC_EMPTY));
    always_comb begin
        o_z = last_z;
        if (stored_vld)
            o_z = entry[rd_ptr];
        else if (push)
            o_z = i_x;
    end
`else
    assign thru  = 1'b0;
    assign o_vld = stored_vld;
    assign o_z   = stored_vld ? entry[rd_ptr] : last_z;
`endif

    assign pop     = o_vld & i_en;
    assign push_st = push & ~thru;
    assign pop_st  = stored_vld & i_en;
    assign o_en    = en_q;
    assign o_cnt   = occ_q;

    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            LIX_OCC_EMPTY: if (push_st) occ_d = LIX_OCC_ONE;
            LIX_OCC_ONE: begin
                if (push_st && !pop_st)
                    occ_d = LIX_OCC_FULL;
                else if (!push_st && pop_st)
                    occ_d = LIX_OCC_EMPTY;
            end
            LIX_OCC_FULL:  if (pop_st) occ_d = LIX_OCC_ONE;
            default:       occ_d = LIX_OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q  <= LIX_OCC_EMPTY;
            en_q   <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            last_z <= '0;
        end else begin
            occ_q <= occ_d;
            // Ready is registered: it drops one cycle late, the second entry absorbs that word.
            en_q  <= (occ_d != LIX_OCC_FULL);
            if (push_st) wr_ptr <= ~wr_ptr;
            if (pop_st)  rd_ptr <= ~rd_ptr;
            if (pop)     last_z <= o_z;
        end
    end

    for (genvar k = 0; k < LIX_SKID_DEPTH; k++) begin : g_entry
        lix_reg #(.W(W)) u_entry (
            .clk_i  (clk_i),
            .rst_ni (~rst_i),
            .i_vld  (push_st),
            .i_en   (wr_ptr == 1'(k)),
            .i_x    (i_x),
            .o_z    (entry[k])
        );
    end

endmodule

// File: tb/tb_lix_skid_rd.sv
// Directed bench for lix_skid_rd (default build, no bypass).
module tb_lix_skid_rd;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        i_vld = 1'b0;
    logic        o_en;
    logic [31:0] i_x   = '0;
    logic        o_vld;
    logic        i_en  = 1'b0;
    logic [31:0] o_z;
    logic [1:0]  o_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    lix_skid_rd #(.W(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_vld (i_vld),
        .o_en  (o_en),
        .i_x   (i_x),
        .o_vld (o_vld),
        .i_en  (i_en),
        .o_z   (o_z),
        .o_cnt (o_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, vld, en;
        logic [31:0] x;
        logic        ev, een;
        logic [31:0] ez;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t tv[18];

    initial begin
        int nxt_in, nxt_out;

        // inputs applied after a negedge; outputs checked before the next posedge
        //          rst vld en x             vld en  z             cnt
        tv[0]  = '{1, 1, 0, 32'hAA,        0, 0, 32'h0,        0};
        tv[1]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,        0};
        tv[2]  = '{0, 1, 0, 32'hDEADBEEF,  0, 1, 32'h0,        0};
        tv[3]  = '{0, 0, 0, 32'h0,         1, 1, 32'hDEADBEEF, 1};
        tv[4]  = '{0, 0, 1, 32'h0,         1, 1, 32'hDEADBEEF, 1};
        tv[5]  = '{0, 0, 0, 32'h0,         0, 1, 32'hDEADBEEF, 0};
        tv[6]  = '{0, 1, 0, 32'h1,         0, 1, 32'hDEADBEEF, 0};
        tv[7]  = '{0, 1, 0, 32'h2,         1, 1, 32'h1,        1};
        tv[8]  = '{0, 1, 0, 32'h3,         1, 0, 32'h1,        2};
        tv[9]  = '{0, 0, 1, 32'h0,         1, 0, 32'h1,        2};
        tv[10] = '{0, 0, 1, 32'h0,         1, 1, 32'h2,        1};
        tv[11] = '{0, 0, 0, 32'h0,         0, 1, 32'h2,        0};
        tv[12] = '{0, 1, 0, 32'hA,         0, 1, 32'h2,        0};
        tv[13] = '{0, 1, 1, 32'hB,         1, 1, 32'hA,        1};
        tv[14] = '{0, 0, 0, 32'h0,         1, 1, 32'hB,        1};
        tv[15] = '{0, 0, 1, 32'h0,         1, 1, 32'hB,        1};
        tv[16] = '{0, 0, 1, 32'h0,         0, 1, 32'hB,        0};
        tv[17] = '{0, 0, 0, 32'h0,         0, 1, 32'hB,        0};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk_i);
            rst_i = tv[i].rst;
            i_vld = tv[i].vld;
            i_en  = tv[i].en;
            i_x   = tv[i].x;
            #1;
            check($sformatf("v%0d o_vld", i), 32'(o_vld), 32'(tv[i].ev));
            check($sformatf("v%0d o_en", i),  32'(o_en),  32'(tv[i].een));
            check($sformatf("v%0d o_z", i),   o_z,        tv[i].ez);
            check($sformatf("v%0d o_cnt", i), 32'(o_cnt), 32'(tv[i].ecnt));
        end

        // Streaming: push and pop every cycle, data 0..15
        nxt_in  = 0;
        nxt_out = 0;
        for (int cyc = 0; cyc < 40 && nxt_out < 16; cyc++) begin
            @(negedge clk_i);
            i_vld = (nxt_in < 16);
            i_x   = 32'(nxt_in);
            i_en  = 1'b1;
            #1;
            if (cyc > 0) check("stream o_cnt", 32'(o_cnt), 32'd1);
            if (o_vld && i_en) begin
                check("stream o_z", o_z, 32'(nxt_out));
                nxt_out++;
            end
            if (i_vld && o_en) nxt_in++;
        end
        check("stream words out", 32'(nxt_out), 32'd16);
        @(negedge clk_i);
        i_vld = 1'b0;
        i_en  = 1'b0;
        #1;
        check("stream drained o_vld", 32'(o_vld), 32'd0);

        // Reset while FULL discards everything immediately
        @(negedge clk_i);
        i_vld = 1'b1; i_x = 32'h11;
        @(negedge clk_i);
        i_x = 32'h22;
        @(negedge clk_i);
        i_vld = 1'b0;
        #1;
        check("full o_cnt", 32'(o_cnt), 32'd2);
        rst_i = 1'b1;
        #1;
        check("midrst o_vld", 32'(o_vld), 32'd0);
        check("midrst o_cnt", 32'(o_cnt), 32'd0);
        check("midrst o_en",  32'(o_en),  32'd0);
        check("midrst o_z",   o_z,        32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("post-rst o_en", 32'(o_en), 32'd1);
        i_vld = 1'b1; i_x = 32'h55;
        @(negedge clk_i);
        i_vld = 1'b0;
        #1;
        check("post-rst o_vld", 32'(o_vld), 32'd1);
        check("post-rst o_z",   o_z,        32'h55);
        check("post-rst o_cnt", 32'(o_cnt), 32'd1);
        i_en = 1'b1;
        @(negedge clk_i);
        i_en = 1'b0;
        #1;
        check("post-rst pop o_cnt", 32'(o_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
